bit_extract: RTL and testbench

- Downstream consumer of the constellation-encoder input FIFO: pops bytes from the FIFO, keeps them in a bit reservoir, and hands the tone-ordering/constellation mapper exactly b bits (0..15) per tone request.
- Bits are packed LSB-first: first byte popped supplies the lowest bits.
- A symbol-boundary flush discards leftover bits.

---
 rtl/bit_extract.sv | 169 ++++++++++++++++
 tb/tb_bit_extract.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_extract.sv
// -----------------------------------------------------------------------------
// bit_extract
//
// Sits between the constellation-encoder input FIFO and the tone-ordering /
// constellation mapper. Bytes popped from the FIFO are appended to a bit
// reservoir, LSB-first: the first byte popped supplies the lowest bits. Each
// accepted tone request takes exactly b bits (0..15) from the bottom of the
// reservoir and returns them right-aligned on data_o. A symbol-boundary flush
// throws away whatever is left.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   fifo_empty_i  FIFO empty flag
//   fifo_re_o     FIFO read enable (registered, one-cycle pulse per byte)
//   fifo_data_i   FIFO read data, valid the cycle after fifo_re_o was sampled
//   req_i         tone bit request, taken when req_i & ready_o at the edge
//   bits_i        number of bits b wanted by this request
//   ready_o       block idle and able to take a request
//   valid_o       one-cycle pulse, data_o carries the requested bits
//   data_o        extracted bits, right-aligned, upper bits zero; held until
//                 the next valid_o
//   flush_i       discard reservoir and abort any in-flight request
//   bit_cnt_o     number of bits currently held in the reservoir
// -----------------------------------------------------------------------------
module bit_extract #(
  parameter int DWIDTH = 8,   // FIFO data width
  parameter int BWIDTH = 4,   // width of the requested bit count
  parameter int RWIDTH = 23   // reservoir width, >= (2**BWIDTH - 2) + DWIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fifo_empty_i,
  output logic                      fifo_re_o,
  input  logic [DWIDTH-1:0]         fifo_data_i,
  input  logic                      req_i,
  input  logic [BWIDTH-1:0]         bits_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic [(2**BWIDTH)-2:0]    data_o,
  input  logic                      flush_i,
  output logic [4:0]                bit_cnt_o
);

  localparam int OWIDTH = (2 ** BWIDTH) - 1;

  // State encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] FETCH = 2'd2;
  localparam logic [1:0] LOAD  = 2'd3;

  logic [1:0]        state_q,   state_d;
  logic [RWIDTH-1:0] res_q,     res_d;
  logic [4:0]        cnt_q,     cnt_d;
  logic [BWIDTH-1:0] b_q,       b_d;
  logic [OWIDTH-1:0] data_q,    data_d;
  logic              valid_q,   valid_d;
  logic              fifo_re_q, fifo_re_d;

  // Low-b-bits mask; b = 0 yields an all-zero mask so data_o reads 0.
  logic [OWIDTH-1:0] take_mask;
  logic              enough_bits;

  assign take_mask   = ~({OWIDTH{1'b1}} << b_q);
  assign enough_bits = (cnt_q >= 5'(b_q));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d   = state_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    b_d       = b_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    fifo_re_d = 1'b0;

    if (flush_i) begin
      // Flush beats everything. A byte already popped in FETCH/LOAD is simply
      // not merged, so it is lost along with the rest of the reservoir.
      state_d = IDLE;
      res_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            b_d     = bits_i;
            state_d = CHECK;
          end
        end

        CHECK: begin
          if (enough_bits) begin
            data_d  = res_q[OWIDTH-1:0] & take_mask;
            res_d   = res_q >> b_q;
            cnt_d   = cnt_q - 5'(b_q);
            valid_d = 1'b1;
            state_d = IDLE;
          end else if (!fifo_empty_i) begin
            // Read enable is registered, so it is raised for exactly the
            // FETCH cycle and the FIFO samples it on the edge leaving FETCH.
            fifo_re_d = 1'b1;
            state_d   = FETCH;
          end
          // Short of bits with an empty FIFO: wait here, no read issued.
        end

        FETCH: begin
          state_d = LOAD;
        end

        LOAD: begin
          // A fetch only happens while cnt < b <= 15, so cnt <= 14 here and the
          // new byte always fits below bit RWIDTH.
          res_d   = res_q | (RWIDTH'(fifo_data_i) << cnt_q);
          cnt_d   = cnt_q + 5'(DWIDTH);
          state_d = CHECK;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the reservoir is a plain register, not a memory, and its contents are
  // architecturally visible through bit_cnt_o/data_o, so it is reset with the
  // rest of the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge value of every other register.
      state_q   <= IDLE;
      res_q     <= '0;
      cnt_q     <= '0;
      b_q       <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fifo_re_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      b_q       <= b_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fifo_re_q <= fifo_re_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ready_o   = (state_q == IDLE);
  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign fifo_re_o = fifo_re_q;
  assign bit_cnt_o = cnt_q;

endmodule

// File: tb/tb_bit_extract.sv
// -----------------------------------------------------------------------------
// tb_bit_extract
//
// Drives bit_extract from a small FIFO model and compares every response with
// a reference model that keeps the reservoir as a queue of individual bits.
// Directed cases first, then randomized requests, flushes and FIFO fills,
// finishing with a reset applied in the middle of a request.
// -----------------------------------------------------------------------------
module tb_bit_extract;

  localparam int DW = 8;
  localparam int BW = 4;
  localparam int OW = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty_i;
  logic          fifo_re_o;
  logic [DW-1:0] fifo_data_i;
  logic          req_i;
  logic [BW-1:0] bits_i;
  logic          ready_o;
  logic          valid_o;
  logic [OW-1:0] data_o;
  logic          flush_i;
  logic [4:0]    bit_cnt_o;

  always #5 clk = ~clk;

  bit_extract #(.DWIDTH(8), .BWIDTH(4), .RWIDTH(23)) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty_i (fifo_empty_i),
    .fifo_re_o    (fifo_re_o),
    .fifo_data_i  (fifo_data_i),
    .req_i        (req_i),
    .bits_i       (bits_i),
    .ready_o      (ready_o),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .flush_i      (flush_i),
    .bit_cnt_o    (bit_cnt_o)
  );

  int n_checks  = 0;
  int n_errors  = 0;
  int re_pulses = 0;
  int underflow = 0;

  // Physical FIFO contents, and the reference model's own view of it.
  logic [7:0] fifo_q[$];
  logic [7:0] model_bytes[$];
  bit         model_bits[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample fifo_re_o before the edge, act as the FIFO after it.
  task automatic tick();
    logic re_s;
    re_s = fifo_re_o;
    @(posedge clk);
    #1;
    if (re_s) begin
      re_pulses++;
      if (fifo_q.size() == 0) underflow++;
      else fifo_data_i = fifo_q.pop_front();
      fifo_empty_i = (fifo_q.size() == 0);
    end
  endtask

  task automatic push_byte(input logic [7:0] by);
    fifo_q.push_back(by);
    model_bytes.push_back(by);
    fifo_empty_i = 1'b0;
  endtask

  // Reference: take b bits off the bottom of the bit queue, pulling whole
  // bytes from the FIFO stream whenever the queue runs short.
  task automatic model_take(input int b, output logic [OW-1:0] d, output int f);
    logic [7:0] by;
    d = '0;
    f = 0;
    while (model_bits.size() < b && model_bytes.size() > 0) begin
      by = model_bytes.pop_front();
      for (int k = 0; k < 8; k++) model_bits.push_back(by[k]);
      f++;
    end
    for (int k = 0; k < b; k++)
      if (model_bits.size() > 0) d[k] = model_bits.pop_front();
  endtask

  // Issue one request. With stall > 0 the FIFO is expected to be short, the
  // block must wait stall cycles without reading, then stall_byte is written.
  task automatic do_req(input string tag, input int b, input int stall, input logic [7:0] stall_byte);
    logic [OW-1:0] exp_data;
    logic [OW-1:0] held;
    int            exp_fetch;
    int            lat;
    int            stall_bad;
    bit            seen;

    check({tag, "_ready"}, 32'(ready_o), 32'd1);
    re_pulses = 0;
    req_i  = 1'b1;
    bits_i = b[3:0];
    tick();                       // accept edge (edge 0)
    req_i  = 1'b0;
    lat    = 0;
    if (stall > 0) begin
      stall_bad = 0;
      for (int i = 0; i < stall; i++) begin
        tick();
        lat++;
        if (fifo_re_o || valid_o) stall_bad++;
      end
      check({tag, "_stall_quiet"}, 32'(stall_bad), 32'd0);
      push_byte(stall_byte);
    end
    model_take(b, exp_data, exp_fetch);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      lat++;
      if (valid_o) seen = 1'b1;
    end
    check({tag, "_valid_seen"}, 32'(seen), 32'd1);
    if (stall == 0) check({tag, "_latency"}, 32'(lat), 32'(1 + 3 * exp_fetch));
    check({tag, "_data"}, 32'(data_o), 32'(exp_data));
    check({tag, "_bitcnt"}, 32'(bit_cnt_o), 32'(model_bits.size()));
    check({tag, "_fetches"}, 32'(re_pulses), 32'(exp_fetch));
    held = data_o;
    tick();
    check({tag, "_valid_pulse"}, 32'(valid_o), 32'd0);
    check({tag, "_data_hold"}, 32'(data_o), 32'(held));
  endtask

  task automatic flush_pulse(input string tag);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    model_bits.delete();
    check({tag, "_bitcnt"}, 32'(bit_cnt_o), 32'd0);
    check({tag, "_ready"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    int b;
    int need;
    bit seen;

    reset        = 1'b1;
    fifo_empty_i = 1'b1;
    fifo_data_i  = '0;
    req_i        = 1'b0;
    bits_i       = '0;
    flush_i      = 1'b0;

    // Reset held across edges: all outputs at their reset values.
    #22;
    check("rst_valid",  32'(valid_o),   32'd0);
    check("rst_re",     32'(fifo_re_o), 32'd0);
    check("rst_data",   32'(data_o),    32'd0);
    check("rst_bitcnt", 32'(bit_cnt_o), 32'd0);
    check("rst_ready",  32'(ready_o),   32'd1);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Single fetch, then a request satisfied from leftover bits.
    push_byte(8'hA5);
    do_req("one_fetch_b3", 3, 0, 8'h00);
    do_req("no_fetch_b5", 5, 0, 8'h00);
    check("one_fetch_empty", 32'(fifo_empty_i), 32'd1);

    // Two fetches for one request.
    push_byte(8'h34);
    push_byte(8'h12);
    do_req("two_fetch_b12", 12, 0, 8'h00);
    do_req("two_fetch_b4", 4, 0, 8'h00);

    // Zero bits, then a stall on an empty FIFO.
    do_req("zero_bits", 0, 0, 8'h00);
    do_req("stall_b8", 8, 10, 8'h5A);

    // Flush while idle with leftover bits.
    push_byte(8'hA5);
    do_req("pre_flush_b3", 3, 0, 8'h00);
    flush_pulse("flush_idle");
    push_byte(8'hF0);
    do_req("post_flush_b4", 4, 0, 8'h00);

    // Flush during LOAD: the popped byte is lost, no valid_o.
    push_byte(8'h77);
    req_i  = 1'b1;
    bits_i = 4'd8;
    tick();                       // edge 0: accept -> CHECK
    req_i  = 1'b0;
    tick();                       // edge 1: -> FETCH
    tick();                       // edge 2: -> LOAD, byte popped
    flush_i = 1'b1;
    tick();                       // edge 3: flushed -> IDLE
    flush_i = 1'b0;
    void'(model_bytes.pop_front());
    model_bits.delete();
    check("flush_load_valid",  32'(valid_o),       32'd0);
    check("flush_load_bitcnt", 32'(bit_cnt_o),     32'd0);
    check("flush_load_ready",  32'(ready_o),       32'd1);
    check("flush_load_fifo",   32'(fifo_q.size()), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid_o) seen = 1'b1;
    end
    check("flush_load_no_valid", 32'(seen), 32'd0);

    // Randomized requests with random FIFO fills and occasional flushes.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 9) == 0) flush_pulse("rnd_flush");
      b    = int'($urandom_range(0, 15));
      need = b - model_bits.size() - 8 * model_bytes.size();
      while (need > 0) begin
        push_byte(8'($urandom));
        need -= 8;
      end
      if ($urandom_range(0, 3) == 0) push_byte(8'($urandom));
      do_req("rnd", b, 0, 8'h00);
      check("rnd_fifo_level", 32'(fifo_q.size()), 32'(model_bytes.size()));
    end

    // Reset in the middle of a request.
    model_bits.delete();
    push_byte(8'hC3);
    req_i  = 1'b1;
    bits_i = 4'd15;
    tick();
    req_i  = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("midrst_ready",  32'(ready_o),   32'd1);
    check("midrst_bitcnt", 32'(bit_cnt_o), 32'd0);
    check("midrst_valid",  32'(valid_o),   32'd0);
    check("midrst_re",     32'(fifo_re_o), 32'd0);
    check("midrst_data",   32'(data_o),    32'd0);
    #20;
    reset = 1'b0;
    tick();

    check("no_underflow", 32'(underflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
